// File: rtl/matrix_mem_responder_pkg.sv
// Shared types for the back-substitution responder: solver opcodes,
// load-port select codes, FSM states and storage read-source selects.
package matrix_mem_responder_pkg;

    typedef enum logic [2:0] {
        OP_GET_N   = 3'b000,
        OP_READ_Y  = 3'b001,
        OP_READ_A  = 3'b010,
        OP_READ_X  = 3'b011,
        OP_WRITE_X = 3'b100,
        OP_INIT    = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        LD_N    = 2'd0,
        LD_Y    = 2'd1,
        LD_A    = 2'd2,
        LD_RSVD = 2'd3
    } ld_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_SERVE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        RS_Y,
        RS_A,
        RS_X,
        RS_NONE
    } rd_src_e;

    // Index width needed to address n entries (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_mem_responder_if.sv
// Load port, solver opcode bus, status and X read port of the responder.
interface matrix_mem_responder_if #(
    parameter int DW = 20,
    parameter int IW = 20
);
    logic          start;
    logic          ld_valid;
    logic          ld_ready;
    logic [1:0]    ld_sel;
    logic [IW-1:0] ld_i;
    logic [IW-1:0] ld_j;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          sol_rst_n;
    logic [2:0]    opcode;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [DW-1:0] out_data;
    logic [DW-1:0] in_data;
    logic          fin;
    logic          done;
    logic          err;
    logic [IW-1:0] wr_cnt;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    // Host/solver side
    modport master (
        output start, ld_valid, ld_sel, ld_i, ld_j, ld_data, ld_last,
        output opcode, i, j, out_data, fin, rd_addr,
        input  ld_ready, sol_rst_n, in_data, done, err, wr_cnt, rd_data
    );

    // Responder side
    modport slave (
        input  start, ld_valid, ld_sel, ld_i, ld_j, ld_data, ld_last,
        input  opcode, i, j, out_data, fin, rd_addr,
        output ld_ready, sol_rst_n, in_data, done, err, wr_cnt, rd_data
    );
endinterface

// File: rtl/matrix_mem_responder_store.sv
// Y/A/X register arrays: one selectable combinational read port for the
// solver, one combinational X read port, synchronous write ports.
module matrix_mem_responder_store
    import matrix_mem_responder_pkg::*;
#(
    parameter int DW    = 20,
    parameter int MAX_N = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_x_i,
    input  logic          we_y_i,
    input  logic          we_a_i,
    input  logic [AW-1:0] ld_row_i,
    input  logic [AW-1:0] ld_col_i,
    input  logic [DW-1:0] ld_data_i,
    input  logic          we_x_i,
    input  logic [AW-1:0] x_addr_i,
    input  logic [DW-1:0] x_data_i,
    input  rd_src_e       rd_src_i,
    input  logic [AW-1:0] rd_row_i,
    input  logic [AW-1:0] rd_col_i,
    output logic [DW-1:0] rd_data_o,
    input  logic [AW-1:0] xr_addr_i,
    output logic [DW-1:0] xr_data_o
);

    logic [DW-1:0] y_q [MAX_N];
    logic [DW-1:0] a_q [MAX_N][MAX_N];
    logic [DW-1:0] x_q [MAX_N];

    // Y and A: written only by the load port, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < MAX_N; r++) begin
                y_q[r] <= '0;
                for (int unsigned c = 0; c < MAX_N; c++) begin
                    a_q[r][c] <= '0;
                end
            end
        end else begin
            if (we_y_i) y_q[ld_row_i] <= ld_data_i;
            if (we_a_i) a_q[ld_row_i][ld_col_i] <= ld_data_i;
        end
    end

    // X: cleared on reset or start (clear wins over a same-cycle write)
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_x_i) begin
            for (int unsigned r = 0; r < MAX_N; r++) begin
                x_q[r] <= '0;
            end
        end else if (we_x_i) begin
            x_q[x_addr_i] <= x_data_i;
        end
    end

    // Solver read port
    always_comb begin
        rd_data_o = '0;
        case (rd_src_i)
            RS_Y:    rd_data_o = y_q[rd_row_i];
            RS_A:    rd_data_o = a_q[rd_row_i][rd_col_i];
            RS_X:    rd_data_o = x_q[rd_row_i];
            default: rd_data_o = '0;
        endcase
    end

    assign xr_data_o = x_q[xr_addr_i];

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the back-substitution solver: loads N/Y/A,
// holds the solver in reset until armed, serves opcode reads, captures X.
import matrix_mem_responder_pkg::*;

module matrix_mem_responder #(
    parameter int DW      = 20,
    parameter int IW      = 20,
    parameter int MAX_N   = 8,
    parameter int TIMEOUT = 4096
) (
    input logic                   clk,
    input logic                   rst,
    matrix_mem_responder_if.slave bus
);

    localparam int            AW      = idx_w(MAX_N);
    localparam int            WDW     = idx_w(TIMEOUT);
    localparam logic [IW-1:0] MAXN_I  = IW'(MAX_N);
    localparam logic [DW-1:0] MAXN_D  = DW'(MAX_N);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic           err_q, err_d;
    logic [IW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [DW-1:0]  n_q, n_d;

    logic           we_y, we_a, we_x, clr_x;
    rd_src_e        rd_src;
    logic [DW-1:0]  st_rd, st_xr;

    logic i_ok, j_ok, ldi_ok, ldj_ok;
    assign i_ok   = bus.i    < MAXN_I;
    assign j_ok   = bus.j    < MAXN_I;
    assign ldi_ok = bus.ld_i < MAXN_I;
    assign ldj_ok = bus.ld_j < MAXN_I;

    matrix_mem_responder_store #(
        .DW    (DW),
        .MAX_N (MAX_N),
        .AW    (AW)
    ) u_store (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_x_i   (clr_x),
        .we_y_i    (we_y),
        .we_a_i    (we_a),
        .ld_row_i  (bus.ld_i[AW-1:0]),
        .ld_col_i  (bus.ld_j[AW-1:0]),
        .ld_data_i (bus.ld_data),
        .we_x_i    (we_x),
        .x_addr_i  (bus.i[AW-1:0]),
        .x_data_i  (bus.out_data),
        .rd_src_i  (rd_src),
        .rd_row_i  (bus.i[AW-1:0]),
        .rd_col_i  (bus.j[AW-1:0]),
        .rd_data_o (st_rd),
        .xr_addr_i (bus.rd_addr[AW-1:0]),
        .xr_data_o (st_xr)
    );

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            wd_q     <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
            wd_q     <= wd_d;
            n_q      <= n_d;
        end
    end

    // Next-state, storage write enables, range errors and watchdog
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        wr_cnt_d = wr_cnt_q;
        wd_d     = wd_q;
        n_d      = n_q;
        we_y     = 1'b0;
        we_a     = 1'b0;
        we_x     = 1'b0;
        clr_x    = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    case (bus.ld_sel)
                        LD_N: begin
                            n_d = bus.ld_data;
                            if (bus.ld_data > MAXN_D) err_d = 1'b1;
                        end
                        LD_Y: begin
                            if (ldi_ok) we_y = 1'b1;
                            else        err_d = 1'b1;
                        end
                        LD_A: begin
                            if (ldi_ok && ldj_ok) we_a = 1'b1;
                            else                  err_d = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                    if (bus.ld_last) state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                wd_d    = '0;
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                case (bus.opcode)
                    OP_READ_Y, OP_READ_X: if (!i_ok) err_d = 1'b1;
                    OP_READ_A: if (!(i_ok && j_ok)) err_d = 1'b1;
                    OP_WRITE_X: begin
                        if (i_ok) begin
                            we_x     = 1'b1;
                            wr_cnt_d = wr_cnt_q + IW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (bus.fin) begin
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
        // start overrides fin/ld_last; Y/A/N writes from a same-cycle beat still land
        if (bus.start) begin
            state_d  = ST_LOAD;
            clr_x    = 1'b1;
            we_x     = 1'b0;
            wr_cnt_d = '0;
            err_d    = 1'b0;
            wd_d     = '0;
        end
    end

    // Solver read response, valid only while serving
    always_comb begin
        rd_src      = RS_NONE;
        bus.in_data = '0;
        if (state_q == ST_SERVE) begin
            case (bus.opcode)
                OP_GET_N:  bus.in_data = n_q;
                OP_READ_Y: begin
                    rd_src = RS_Y;
                    if (i_ok) bus.in_data = st_rd;
                end
                OP_READ_A: begin
                    rd_src = RS_A;
                    if (i_ok && j_ok) bus.in_data = st_rd;
                end
                OP_READ_X: begin
                    rd_src = RS_X;
                    if (i_ok) bus.in_data = st_rd;
                end
                default: bus.in_data = '0;
            endcase
        end
    end

    assign bus.ld_ready  = (state_q == ST_LOAD);
    assign bus.sol_rst_n = (state_q == ST_SERVE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.rd_data   = (bus.rd_addr < MAXN_I) ? st_xr : '0;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder with a small in-bench solver.
module tb_matrix_mem_responder;
    import matrix_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;

    matrix_mem_responder_if #(.DW(20), .IW(20)) bus ();

    matrix_mem_responder #(
        .DW      (20),
        .IW      (20),
        .MAX_N   (8),
        .TIMEOUT (4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic ld_beat(input logic [1:0] sel, input logic [19:0] li, input logic [19:0] lj,
                           input logic [19:0] d, input logic last);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_sel   = sel;
        bus.ld_i     = li;
        bus.ld_j     = lj;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1 chk("ld_ready_in_load", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic bus_op(input logic [2:0] op, input logic [19:0] ii, input logic [19:0] jj,
                          input logic [19:0] od, output logic [19:0] rd);
        @(negedge clk);
        bus.opcode   = op;
        bus.i        = ii;
        bus.j        = jj;
        bus.out_data = od;
        #1 rd = bus.in_data;
    endtask

    // After the last load beat: one ARM cycle, then SERVE
    task automatic arm_to_serve(input string tag);
        @(negedge clk);
        #1 chk({tag, "_arm_sol_rst_n"}, 32'(bus.sol_rst_n), 32'd0);
        chk({tag, "_arm_ld_ready"}, 32'(bus.ld_ready), 32'd0);
        @(negedge clk);
        #1 chk({tag, "_serve_sol_rst_n"}, 32'(bus.sol_rst_n), 32'd1);
    endtask

    logic [19:0] d, acc, a, x;
    logic [39:0] prod;
    int          k;

    initial begin
        bus.start = 0; bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_i = 0; bus.ld_j = 0;
        bus.ld_data = 0; bus.ld_last = 0; bus.opcode = OP_INIT; bus.i = 0; bus.j = 0;
        bus.out_data = 0; bus.fin = 0; bus.rd_addr = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        chk("rst_in_data", 32'(bus.in_data), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;

        // Full solve: N=2, A=[[1,3],[0,1]], Y=[10,4]
        pulse_start();
        #1 chk("load_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("load_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);
        ld_beat(LD_N, 0, 0, 20'd2, 0);
        ld_beat(LD_Y, 0, 0, 20'd10, 0);
        ld_beat(LD_Y, 1, 0, 20'd4, 0);
        ld_beat(LD_A, 0, 0, 20'd1, 0);
        ld_beat(LD_A, 0, 1, 20'd3, 0);
        ld_beat(LD_A, 1, 0, 20'd0, 0);
        ld_beat(LD_A, 1, 1, 20'd1, 1);
        arm_to_serve("solve");
        bus_op(OP_GET_N, 0, 0, 0, d);
        chk("solve_get_n", 32'(d), 32'd2);
        // row 1
        bus_op(OP_READ_Y, 1, 0, 0, acc);
        bus_op(OP_READ_A, 1, 1, 0, a);
        bus_op(OP_WRITE_X, 1, 0, acc, d);
        // row 0
        bus_op(OP_READ_Y, 0, 0, 0, acc);
        bus_op(OP_READ_A, 0, 1, 0, a);
        bus_op(OP_READ_X, 1, 0, 0, x);
        chk("solve_read_x1", 32'(x), 32'd4);
        prod = a * x;
        acc  = acc - prod[19:0];
        bus_op(OP_READ_A, 0, 0, 0, a);
        bus_op(OP_WRITE_X, 0, 0, acc, d);
        @(negedge clk);
        bus.opcode = OP_INIT;
        bus.fin    = 1'b1;
        @(negedge clk);
        bus.fin = 1'b0;
        #1 chk("solve_done", 32'(bus.done), 32'd1);
        chk("solve_wr_cnt", 32'(bus.wr_cnt), 32'd2);
        chk("solve_err", 32'(bus.err), 32'd0);
        chk("solve_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);
        bus.rd_addr = 1;
        #1 chk("solve_x1", 32'(bus.rd_data), 32'h4);
        bus.rd_addr = 0;
        #1 chk("solve_x0", 32'(bus.rd_data), 32'hFFFFE);
        bus.rd_addr = 8;
        #1 chk("rd_addr_oob", 32'(bus.rd_data), 32'h0);

        // Partial reload of A[1][0], same-cycle READ_A, then start mid-SERVE
        pulse_start();
        ld_beat(LD_A, 1, 0, 20'h00123, 1);
        arm_to_serve("reada");
        bus_op(OP_READ_A, 1, 0, 0, d);
        chk("reada_a10", 32'(d), 32'h00123);
        bus_op(OP_READ_Y, 0, 0, 0, d);
        chk("reada_y0_retained", 32'(d), 32'd10);
        bus_op(OP_WRITE_X, 1, 0, 20'h55, d);
        bus_op(OP_READ_X, 1, 0, 0, d);
        chk("reada_x1_written", 32'(d), 32'h55);
        chk("reada_wr_cnt", 32'(bus.wr_cnt), 32'd1);
        bus_op(OP_READ_Y, 8, 0, 0, d);
        chk("read_y_i8", 32'(d), 32'd0);
        bus_op(OP_INIT, 0, 0, 0, d);
        chk("read_y_i8_err", 32'(bus.err), 32'd1);
        pulse_start();
        bus.rd_addr = 1;
        #1 chk("midserve_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("midserve_x1", 32'(bus.rd_data), 32'd0);
        chk("midserve_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        chk("midserve_err", 32'(bus.err), 32'd0);
        chk("midserve_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);

        // Out-of-range load beat is dropped and flags err
        ld_beat(LD_A, 9, 0, 20'h777, 0);
        @(negedge clk);
        #1 chk("ld_i9_err", 32'(bus.err), 32'd1);
        ld_beat(LD_N, 0, 0, 20'd2, 1);
        arm_to_serve("oob");
        bus_op(OP_READ_Y, 8, 0, 0, d);
        chk("oob_read_y_i8", 32'(d), 32'd0);

        // Watchdog: fresh start, solver never finishes
        bus_op(OP_INIT, 0, 0, 0, d);
        pulse_start();
        ld_beat(LD_N, 0, 0, 20'd2, 1);
        arm_to_serve("wd");
        chk("wd_err_before", 32'(bus.err), 32'd0);
        k = 0;
        while (!bus.done && k < 5000) begin
            @(negedge clk);
            #1 k++;
        end
        chk("wd_cycles", 32'(k), 32'd4096);
        chk("wd_done", 32'(bus.done), 32'd1);
        chk("wd_err", 32'(bus.err), 32'd1);
        chk("wd_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);

        // N > MAX_N flags err; rst during LOAD clears everything
        pulse_start();
        ld_beat(LD_N, 0, 0, 20'd9, 0);
        @(negedge clk);
        #1 chk("n9_err", 32'(bus.err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("rstload_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rstload_done", 32'(bus.done), 32'd0);
        chk("rstload_err", 32'(bus.err), 32'd0);
        chk("rstload_sol_rst_n", 32'(bus.sol_rst_n), 32'd0);
        rst = 1'b0;
        pulse_start();
        ld_beat(LD_Y, 0, 0, 20'd7, 1);
        arm_to_serve("after_rst");
        bus_op(OP_GET_N, 0, 0, 0, d);
        chk("after_rst_n", 32'(d), 32'd0);
        bus_op(OP_READ_Y, 1, 0, 0, d);
        chk("after_rst_y1", 32'(d), 32'd0);
        bus_op(OP_READ_Y, 0, 0, 0, d);
        chk("after_rst_y0", 32'(d), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
